// File: rtl/hp_traffic_gen.sv
// AXI4 burst traffic engine: one command produces a run of 4 KB INCR bursts,
// either writing a per-lane incrementing pattern or checksumming read data.
module hp_traffic_gen #(
  parameter int HP_ADDR_WIDTH   = 48,
  parameter int HP_DATA_WIDTH   = 128,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [HP_ADDR_WIDTH-1:0]   cmd_start_addr,
  input  logic [HP_ADDR_WIDTH-1:0]   cmd_end_addr,
  input  logic [127:0]               cmd_start_value,
  input  logic [127:0]               cmd_stride,
  input  logic                       cmd_mode,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                checksum,
  output logic                       resp_err,
  output logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
  output logic [7:0]                 hp_awlen,
  output logic [2:0]                 hp_awsize,
  output logic [1:0]                 hp_awburst,
  output logic                       hp_awvalid,
  input  logic                       hp_awready,
  output logic [HP_DATA_WIDTH-1:0]   hp_wdata,
  output logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
  output logic                       hp_wlast,
  output logic                       hp_wvalid,
  input  logic                       hp_wready,
  input  logic [1:0]                 hp_bresp,
  input  logic                       hp_bvalid,
  output logic                       hp_bready,
  output logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
  output logic [7:0]                 hp_arlen,
  output logic [2:0]                 hp_arsize,
  output logic [1:0]                 hp_arburst,
  output logic                       hp_arvalid,
  input  logic                       hp_arready,
  input  logic [HP_DATA_WIDTH-1:0]   hp_rdata,
  input  logic [1:0]                 hp_rresp,
  input  logic                       hp_rlast,
  input  logic                       hp_rvalid,
  output logic                       hp_rready
);

  localparam int PW = HP_ADDR_WIDTH - 12;
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [PW-1:0]   start_pg_q, start_pg_d;
  logic [PW-1:0]   nbursts_q, nbursts_d;
  logic [PW-1:0]   issued_q, issued_d;
  logic [PW-1:0]   cpl_q, cpl_d;
  logic [PW-1:0]   wburst_q, wburst_d;
  logic [7:0]      wbeat_q, wbeat_d;
  logic [7:0]      rbeat_q, rbeat_d;
  logic [7:0]      outst_q, outst_d;
  logic            axvalid_q, axvalid_d;
  logic [PW-1:0]   axaddr_q, axaddr_d;
  logic            wvalid_q, wvalid_d;
  logic            wlast_q, wlast_d;
  logic [127:0]    wdata_q, wdata_d;
  logic [127:0]    stride_q, stride_d;
  logic [31:0]     checksum_q, checksum_d;
  logic            err_q, err_d;

  logic [PW-1:0]   start_pg_in, end_pg_in, nb_in;
  logic [PW-1:0]   issued_next, cpl_next;
  logic [127:0]    wdata_inc;
  logic [31:0]     rlane [4];
  logic [31:0]     rsum;
  logic            ax_hs, w_hs, b_hs, r_hs, cpl_evt, run_end;
  logic            unused_low_bits;

  // Sub-page address bits play no part: the range is whole 4 KB pages.
  assign start_pg_in     = cmd_start_addr[HP_ADDR_WIDTH-1:12];
  assign end_pg_in       = cmd_end_addr[HP_ADDR_WIDTH-1:12];
  assign nb_in           = (end_pg_in > start_pg_in) ? (end_pg_in - start_pg_in) : '0;
  assign unused_low_bits = ^{cmd_start_addr[11:0], cmd_end_addr[11:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_inc[gi*32 +: 32] = wdata_q[gi*32 +: 32] + stride_q[gi*32 +: 32];
      assign rlane[gi]              = hp_rdata[gi*32 +: 32];
    end
  endgenerate
  assign rsum = rlane[0] + rlane[1] + rlane[2] + rlane[3];

  assign ax_hs       = axvalid_q & (mode_q ? hp_arready : hp_awready);
  assign w_hs        = wvalid_q & hp_wready;
  assign b_hs        = hp_bvalid & hp_bready;
  assign r_hs        = hp_rvalid & hp_rready;
  // A read burst completes at its beat-255 position whatever rlast says.
  assign cpl_evt     = mode_q ? (r_hs && (rbeat_q == 8'hFF)) : b_hs;
  assign issued_next = issued_q + PW'(ax_hs);
  assign cpl_next    = cpl_q + PW'(cpl_evt);
  assign run_end     = (cpl_next == nbursts_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_RUN;
      S_RUN:   if (run_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    hp_bready = (state_q == S_RUN) & ~mode_q;
    hp_rready = (state_q == S_RUN) & mode_q;
  end

  always_comb begin
    mode_d     = mode_q;
    start_pg_d = start_pg_q;
    nbursts_d  = nbursts_q;
    issued_d   = issued_q;
    cpl_d      = cpl_q;
    wburst_d   = wburst_q;
    wbeat_d    = wbeat_q;
    rbeat_d    = rbeat_q;
    outst_d    = outst_q;
    axvalid_d  = axvalid_q;
    axaddr_d   = axaddr_q;
    wvalid_d   = wvalid_q;
    wlast_d    = wlast_q;
    wdata_d    = wdata_q;
    stride_d   = stride_q;
    checksum_d = checksum_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d     = cmd_mode;
          start_pg_d = start_pg_in;
          nbursts_d  = nb_in;
          issued_d   = '0;
          cpl_d      = '0;
          wburst_d   = '0;
          wbeat_d    = '0;
          rbeat_d    = '0;
          outst_d    = '0;
          axvalid_d  = (nb_in != '0);
          axaddr_d   = start_pg_in;
          wvalid_d   = (nb_in != '0) & ~cmd_mode;
          wlast_d    = 1'b0;
          wdata_d    = cmd_start_value;
          stride_d   = cmd_stride;
          checksum_d = '0;
          err_d      = 1'b0;
        end
      end
      S_RUN: begin
        issued_d = issued_next;
        cpl_d    = cpl_next;
        if (ax_hs && !cpl_evt)      outst_d = outst_q + 8'd1;
        else if (!ax_hs && cpl_evt) outst_d = outst_q - 8'd1;
        if (w_hs) begin
          wdata_d = wdata_inc;
          wbeat_d = wbeat_q + 8'd1;
          if (wbeat_q == 8'hFF) wburst_d = wburst_q + PW'(1);
        end
        if (b_hs && (hp_bresp != 2'b00)) err_d = 1'b1;
        if (r_hs) begin
          checksum_d = checksum_q + rsum;
          rbeat_d    = rbeat_q + 8'd1;
          if ((hp_rresp != 2'b00) || (hp_rlast != (rbeat_q == 8'hFF))) err_d = 1'b1;
        end
        if (run_end) begin
          axvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          wlast_d   = 1'b0;
        end else begin
          // A pending valid keeps its payload; only a handshake frees the slot.
          if (!axvalid_q || ax_hs) axvalid_d = (issued_next < nbursts_q) && (outst_d < MAX_OUT);
          axaddr_d = start_pg_q + issued_next;
          if (!wvalid_q || w_hs) wvalid_d = !mode_q && (wburst_d < nbursts_q);
          wlast_d = wvalid_d && (wbeat_d == 8'hFF);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q     <= 1'b0;
      start_pg_q <= '0;
      nbursts_q  <= '0;
      issued_q   <= '0;
      cpl_q      <= '0;
      wburst_q   <= '0;
      wbeat_q    <= '0;
      rbeat_q    <= '0;
      outst_q    <= '0;
      axvalid_q  <= 1'b0;
      axaddr_q   <= '0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      wdata_q    <= '0;
      stride_q   <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      start_pg_q <= start_pg_d;
      nbursts_q  <= nbursts_d;
      issued_q   <= issued_d;
      cpl_q      <= cpl_d;
      wburst_q   <= wburst_d;
      wbeat_q    <= wbeat_d;
      rbeat_q    <= rbeat_d;
      outst_q    <= outst_d;
      axvalid_q  <= axvalid_d;
      axaddr_q   <= axaddr_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      wdata_q    <= wdata_d;
      stride_q   <= stride_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
    end
  end

  assign hp_awaddr  = {axaddr_q, 12'h000};
  assign hp_awlen   = 8'hFF;
  assign hp_awsize  = 3'b100;
  assign hp_awburst = 2'b01;
  assign hp_awvalid = axvalid_q & ~mode_q;
  assign hp_araddr  = {axaddr_q, 12'h000};
  assign hp_arlen   = 8'hFF;
  assign hp_arsize  = 3'b100;
  assign hp_arburst = 2'b01;
  assign hp_arvalid = axvalid_q & mode_q;
  assign hp_wdata   = wdata_q;
  assign hp_wstrb   = '1;
  assign hp_wlast   = wlast_q;
  assign hp_wvalid  = wvalid_q;
  assign checksum   = checksum_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_hp_traffic_gen.sv
// Directed bench for hp_traffic_gen: a small AXI slave with bookkeeping,
// a table of commands with hand-computed results, and a mid-write reset.
module tb_hp_traffic_gen;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_valid, cmd_ready, cmd_mode;
  logic [47:0]  cmd_start_addr, cmd_end_addr;
  logic [127:0] cmd_start_value, cmd_stride;
  logic         busy, done, resp_err;
  logic [31:0]  checksum;
  logic [47:0]  hp_awaddr, hp_araddr;
  logic [7:0]   hp_awlen, hp_arlen;
  logic [2:0]   hp_awsize, hp_arsize;
  logic [1:0]   hp_awburst, hp_arburst;
  logic         hp_awvalid, hp_arvalid, hp_wvalid, hp_wlast, hp_bready, hp_rready;
  logic [127:0] hp_wdata;
  logic [15:0]  hp_wstrb;
  logic         awready, wready, arready, bvalid, rvalid, rlast;
  logic [1:0]   bresp, rresp;
  logic [127:0] rdata;

  hp_traffic_gen dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start_addr(cmd_start_addr), .cmd_end_addr(cmd_end_addr),
    .cmd_start_value(cmd_start_value), .cmd_stride(cmd_stride), .cmd_mode(cmd_mode),
    .busy(busy), .done(done), .checksum(checksum), .resp_err(resp_err),
    .hp_awaddr(hp_awaddr), .hp_awlen(hp_awlen), .hp_awsize(hp_awsize),
    .hp_awburst(hp_awburst), .hp_awvalid(hp_awvalid), .hp_awready(awready),
    .hp_wdata(hp_wdata), .hp_wstrb(hp_wstrb), .hp_wlast(hp_wlast),
    .hp_wvalid(hp_wvalid), .hp_wready(wready),
    .hp_bresp(bresp), .hp_bvalid(bvalid), .hp_bready(hp_bready),
    .hp_araddr(hp_araddr), .hp_arlen(hp_arlen), .hp_arsize(hp_arsize),
    .hp_arburst(hp_arburst), .hp_arvalid(hp_arvalid), .hp_arready(arready),
    .hp_rdata(rdata), .hp_rresp(rresp), .hp_rlast(rlast),
    .hp_rvalid(rvalid), .hp_rready(hp_rready)
  );

  typedef struct {
    logic         mode;
    logic [47:0]  sa, ea;
    logic [127:0] sv, st;
    int           err_burst, early_beat, r_gap;
    bit           stall;
    int           exp_bursts, exp_beats;
    logic [127:0] exp_last;
    logic [31:0]  exp_chk;
    logic         exp_err;
    int           exp_maxout;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Slave knobs, written by the stimulus process only.
  int cfg_err_burst = -1, cfg_early = -1, cfg_gap = 0;
  bit cfg_stall = 1'b0;

  // Monitor state, written by the slave process only.
  int aw_cnt, ar_cnt, w_cnt, b_cnt, r_cnt, max_out, done_cnt;
  int attr_bad, data_bad, chan_bad;
  int acc_cyc, done_cyc, last_cpl_cyc, first_w_cyc, last_w_cyc;
  logic         busy_at_done, m_mode;
  logic [35:0]  base_pg;
  logic [127:0] exp_w, m_stride, last_w, prev_wdata;
  logic [47:0]  exp_addr, prev_awaddr, prev_araddr;
  logic         prev_aw_stall, prev_ar_stall, prev_w_stall, prev_wlast;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0; rdata = '0;
    aw_cnt = 0; ar_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; max_out = 0; done_cnt = 0;
    attr_bad = 0; data_bad = 0; chan_bad = 0; acc_cyc = 0; done_cyc = 0;
    last_cpl_cyc = -1; first_w_cyc = 0; last_w_cyc = 0; busy_at_done = 1'b0; m_mode = 1'b0;
    base_pg = '0; exp_w = '0; m_stride = '0; last_w = '0; prev_wdata = '0; exp_addr = '0;
    prev_awaddr = '0; prev_araddr = '0;
    prev_aw_stall = 1'b0; prev_ar_stall = 1'b0; prev_w_stall = 1'b0; prev_wlast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        prev_aw_stall = 1'b0; prev_ar_stall = 1'b0; prev_w_stall = 1'b0;
      end else begin
        int m;
        awready = cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = 1'b1;
        m = (aw_cnt < w_cnt / 256) ? aw_cnt : w_cnt / 256;
        bvalid = (b_cnt < m);
        bresp  = (b_cnt == cfg_err_burst) ? 2'b10 : 2'b00;
        rvalid = (r_cnt < ar_cnt * 256) && (cyc % (cfg_gap + 1) == 0);
        rdata  = {4{32'(r_cnt % 256)}};
        rlast  = (r_cnt % 256 == 255) || (r_cnt % 256 == cfg_early);
      end
      #1;
      if (rstn) begin
        int outs;
        if (cmd_valid && cmd_ready) begin
          aw_cnt = 0; ar_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; max_out = 0; done_cnt = 0;
          attr_bad = 0; data_bad = 0; chan_bad = 0; last_cpl_cyc = -1;
          base_pg = cmd_start_addr[47:12]; m_mode = cmd_mode;
          exp_w = cmd_start_value; m_stride = cmd_stride; acc_cyc = cyc;
        end
        if (prev_aw_stall && !(hp_awvalid && hp_awaddr == prev_awaddr)) chan_bad++;
        if (prev_ar_stall && !(hp_arvalid && hp_araddr == prev_araddr)) chan_bad++;
        if (prev_w_stall && !(hp_wvalid && hp_wdata == prev_wdata && hp_wlast == prev_wlast)) chan_bad++;
        prev_aw_stall = hp_awvalid && !awready; prev_awaddr = hp_awaddr;
        prev_ar_stall = hp_arvalid && !arready; prev_araddr = hp_araddr;
        prev_w_stall  = hp_wvalid && !wready;   prev_wdata  = hp_wdata; prev_wlast = hp_wlast;
        if (m_mode ? (hp_awvalid || hp_wvalid) : hp_arvalid) chan_bad++;
        if (hp_awvalid && awready) begin
          exp_addr = {base_pg, 12'h000} + 48'(aw_cnt) * 48'h1000;
          if (hp_awaddr != exp_addr || hp_awlen != 8'hFF || hp_awsize != 3'b100 || hp_awburst != 2'b01) attr_bad++;
          aw_cnt++;
        end
        if (hp_arvalid && arready) begin
          exp_addr = {base_pg, 12'h000} + 48'(ar_cnt) * 48'h1000;
          if (hp_araddr != exp_addr || hp_arlen != 8'hFF || hp_arsize != 3'b100 || hp_arburst != 2'b01) attr_bad++;
          ar_cnt++;
        end
        if (hp_wvalid && wready) begin
          if (hp_wdata != exp_w || hp_wstrb != 16'hFFFF || hp_wlast != (w_cnt % 256 == 255)) data_bad++;
          last_w = hp_wdata;
          if (w_cnt == 0) first_w_cyc = cyc;
          last_w_cyc = cyc;
          for (int l = 0; l < 4; l++) exp_w[l*32 +: 32] = exp_w[l*32 +: 32] + m_stride[l*32 +: 32];
          w_cnt++;
        end
        if (bvalid && hp_bready) begin
          b_cnt++;
          last_cpl_cyc = cyc;
        end
        if (rvalid && hp_rready) begin
          r_cnt++;
          if (r_cnt % 256 == 0) last_cpl_cyc = cyc;
        end
        outs = m_mode ? (ar_cnt - r_cnt / 256) : (aw_cnt - b_cnt);
        if (outs > max_out) max_out = outs;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mode, input logic [47:0] sa, input logic [47:0] ea,
                              input logic [127:0] sv, input logic [127:0] st,
                              input int eb, input int ee, input int gap, input bit stall,
                              input int nb, input int nbeats, input logic [127:0] last,
                              input logic [31:0] chk, input logic err, input int mo);
    vec_t v;
    v.mode = mode; v.sa = sa; v.ea = ea; v.sv = sv; v.st = st;
    v.err_burst = eb; v.early_beat = ee; v.r_gap = gap; v.stall = stall;
    v.exp_bursts = nb; v.exp_beats = nbeats; v.exp_last = last;
    v.exp_chk = chk; v.exp_err = err; v.exp_maxout = mo;
    return v;
  endfunction

  task automatic start_cmd(input vec_t v);
    int n;
    logic ev;
    cfg_err_burst = v.err_burst; cfg_early = v.early_beat; cfg_gap = v.r_gap; cfg_stall = v.stall;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = v.mode; cmd_start_addr = v.sa; cmd_end_addr = v.ea;
    cmd_start_value = v.sv; cmd_stride = v.st;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("start_busy_ready", {busy, cmd_ready}, 2'b10);
    ev = (v.exp_bursts > 0);
    check("start_valids", {hp_awvalid, hp_wvalid, hp_arvalid}, v.mode ? {2'b00, ev} : {ev, ev, 1'b0});
  endtask

  task automatic finish_cmd(input vec_t v, input int idx);
    int n = 0;
    while (done_cnt == 0 && n < 40000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("done_seen", done_cnt != 0, 1'b1);
    @(negedge clk);
    #2;
    check("ready_after_done", {cmd_ready, done}, 2'b10);
    check("done_once", done_cnt, 1);
    check("busy_at_done", busy_at_done, 1'b0);
    check("bursts", v.mode ? ar_cnt : aw_cnt, v.exp_bursts);
    check("beats", v.mode ? r_cnt : w_cnt, v.exp_beats);
    if (!v.mode && v.exp_bursts > 0) check("last_wdata", last_w, v.exp_last);
    if (!v.mode && v.exp_bursts > 0 && !v.stall) check("w_throughput", last_w_cyc - first_w_cyc, v.exp_beats - 1);
    check("addr_attr_bad", attr_bad, 0);
    check("wdata_wlast_bad", data_bad, 0);
    check("chan_stability_bad", chan_bad, 0);
    check("checksum", checksum, v.exp_chk);
    check("resp_err", resp_err, v.exp_err);
    check("done_timing", done_cyc, (v.exp_bursts > 0) ? last_cpl_cyc + 1 : acc_cyc + 2);
    check("max_out_bound", max_out <= 8, 1'b1);
    if (v.exp_maxout >= 0) check("max_out", max_out, v.exp_maxout);
    $display("cmd %0d mode=%0d bursts=%0d beats=%0d checksum=%0d resp_err=%0d done_cycle=%0d",
             idx, v.mode, v.mode ? ar_cnt : aw_cnt, v.mode ? r_cnt : w_cnt, checksum, resp_err,
             done_cyc - acc_cyc);
  endtask

  vec_t vecs[7];
  vec_t rv, cv;

  initial begin
    int n;
    cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_start_addr = '0; cmd_end_addr = '0;
    cmd_start_value = '0; cmd_stride = '0;

    vecs[0] = mk(1'b0, 48'h1000, 48'h3000, 128'h00000003_00000002_00000001_00000000,
                 128'h00000001_00000001_00000001_00000001, -1, -1, 0, 1'b0, 2, 512,
                 128'h00000202_00000201_00000200_000001FF, 32'd0, 1'b0, -1);
    vecs[1] = mk(1'b1, 48'h0, 48'h1000, '0, '0, -1, -1, 0, 1'b0, 1, 256, '0, 32'd130560, 1'b0, -1);
    vecs[2] = mk(1'b1, 48'h0, 48'h14000, '0, '0, -1, -1, 1, 1'b0, 20, 5120, '0, 32'd2611200, 1'b0, 8);
    vecs[3] = mk(1'b0, 48'h10000, 48'h13000, 128'hFFFFFFFF_00000000_00000000_00000010,
                 128'h00000001_00000003_00000002_00000004, 1, -1, 0, 1'b1, 3, 768,
                 128'h000002FE_000008FD_000005FE_00000C0C, 32'd0, 1'b1, -1);
    vecs[4] = mk(1'b0, 48'h0, 48'h1000, '0, '0, -1, -1, 0, 1'b0, 1, 256, '0, 32'd0, 1'b0, -1);
    vecs[5] = mk(1'b1, 48'h2000, 48'h3000, '0, '0, -1, 100, 0, 1'b0, 1, 256, '0, 32'd130560, 1'b1, -1);
    vecs[6] = mk(1'b1, 48'h5000, 48'h5000, '0, '0, -1, -1, 0, 1'b0, 0, 0, '0, 32'd0, 1'b0, -1);

    repeat (3) @(negedge clk);
    check("reset_ctrl", {cmd_ready, busy, done, resp_err, hp_awvalid, hp_wvalid, hp_arvalid,
                         hp_bready, hp_rready, hp_wlast}, 10'b1000000000);
    check("reset_data", {checksum, hp_awaddr, hp_wdata[47:0]}, '0);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start_cmd(vecs[i]);
      finish_cmd(vecs[i], i);
    end

    // Reset while the second of four write bursts is streaming.
    rv = mk(1'b0, 48'h0, 48'h4000, '0, 128'h00000001_00000001_00000001_00000001,
            -1, -1, 0, 1'b0, 4, 1024, '0, 32'd0, 1'b0, -1);
    start_cmd(rv);
    n = 0;
    while (w_cnt < 300 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("rst_mid_write_reached", {w_cnt >= 300, hp_wvalid}, 2'b11);
    rstn = 1'b0;
    #1;
    check("rst_outputs", {hp_awvalid, hp_wvalid, hp_arvalid, hp_bready, hp_rready, busy, done, cmd_ready},
          8'b00000001);
    check("rst_wdata", hp_wdata, '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_ready_after", cmd_ready, 1'b1);
    $display("cmd reset mid-write at beat %0d", w_cnt);

    cv = mk(1'b0, 48'h0, 48'h1000, 128'h00000007_00000006_00000005_00000004,
            128'h00000001_00000001_00000001_00000001, -1, -1, 0, 1'b0, 1, 256,
            128'h00000106_00000105_00000104_00000103, 32'd0, 1'b0, -1);
    start_cmd(cv);
    finish_cmd(cv, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
